// File: rtl/clock_domain_reset_sequencer.sv
// Per-domain reset sequencer with clock gating.
// Boot-time staggered release, run-time masked re-reset with gated release.
module clock_domain_reset_sequencer #(
    parameter int unsigned NUM_OUT = 5,
    parameter int unsigned GAP     = 4,
    parameter int unsigned PULSE   = 8
) (
    input  logic               clock,
    input  logic               reset,
    output logic [NUM_OUT-1:0] out_reset,
    output logic [NUM_OUT-1:0] out_clock_en,
    output logic               boot_done,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUM_OUT-1:0] req_mask,
    output logic               done
);

    localparam int unsigned MAXC = (GAP > PULSE) ? GAP : PULSE;
    localparam int unsigned CW   = $clog2(MAXC) + 1;
    localparam int unsigned IW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE - 1);
    localparam logic [CW-1:0] GATE_LAST  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_ASSERT,
        S_GATE,
        S_RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic               boot_done_q, boot_done_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic [NUM_OUT-1:0] cen_q, cen_d;
    logic               done_q, done_d;
    logic               hs;

    assign hs = req_valid && (state_q == S_IDLE);

    // State, counter, boot index and latched mask registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_BOOT;
            cnt_q       <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            boot_done_q <= boot_done_d;
        end
    end

    // Next-state logic; the counter is cleared on every state entry
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        boot_done_d = boot_done_q;
        case (state_q)
            S_BOOT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d     = S_IDLE;
                        boot_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_IDLE: begin
                if (hs && (req_mask != '0)) begin
                    mask_d  = req_mask;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GATE;
                end
            end
            S_GATE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == GATE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_BOOT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next values, chosen so each output flop changes on the transition
    always_comb begin
        rst_d  = rst_q;
        cen_d  = cen_q;
        done_d = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (cnt_q == GAP_LAST) begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (idx_q == IW'(i)) begin
                            rst_d[i] = 1'b0;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (hs) begin
                    if (req_mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rst_d = rst_q | req_mask;
                    end
                end
            end
            S_ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    cen_d = cen_q & ~mask_q;
                end
            end
            S_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    rst_d = rst_q & ~mask_q;
                end
            end
            S_RELEASE: begin
                cen_d  = cen_q | mask_q;
                done_d = 1'b1;
            end
            default: begin
                rst_d = '1;
                cen_d = '1;
            end
        endcase
    end

    // Registered per-domain outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_q  <= '1;
            cen_q  <= '1;
            done_q <= 1'b0;
        end else begin
            rst_q  <= rst_d;
            cen_q  <= cen_d;
            done_q <= done_d;
        end
    end

    assign out_reset    = rst_q;
    assign out_clock_en = cen_q;
    assign boot_done    = boot_done_q;
    assign done         = done_q;
    assign req_ready    = (state_q == S_IDLE);

endmodule

// File: tb/tb_clock_domain_reset_sequencer.sv
// Directed bench for clock_domain_reset_sequencer.
// Default instance plus a GAP=1/PULSE=1/NUM_OUT=1 instance.
module tb_clock_domain_reset_sequencer;

    logic       clock;
    logic       rst_a, rst_b;
    logic [4:0] ores_a, ocen_a, mask_a;
    logic       bdone_a, valid_a, ready_a, done_a;
    logic [0:0] ores_b, ocen_b, mask_b;
    logic       bdone_b, valid_b, ready_b, done_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    int t     = 0;

    clock_domain_reset_sequencer dut_a (
        .clock        (clock),
        .reset        (rst_a),
        .out_reset    (ores_a),
        .out_clock_en (ocen_a),
        .boot_done    (bdone_a),
        .req_valid    (valid_a),
        .req_ready    (ready_a),
        .req_mask     (mask_a),
        .done         (done_a)
    );

    clock_domain_reset_sequencer #(
        .NUM_OUT (1),
        .GAP     (1),
        .PULSE   (1)
    ) dut_b (
        .clock        (clock),
        .reset        (rst_b),
        .out_reset    (ores_b),
        .out_clock_en (ocen_b),
        .boot_done    (bdone_b),
        .req_valid    (valid_b),
        .req_ready    (ready_b),
        .req_mask     (mask_b),
        .done         (done_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic logic [4:0] boot_rst(input int c);
        logic [4:0] r;
        r = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            if (c >= (i + 1) * 4) r[i] = 1'b0;
        end
        return r;
    endfunction

    initial begin
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        valid_a = 1'b0;
        mask_a  = '0;
        valid_b = 1'b0;
        mask_b  = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ores", ores_a, 5'b11111);
        chk("rst_ocen", ocen_a, 5'b11111);
        chk("rst_bdone", bdone_a, 0);
        chk("rst_ready", ready_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_b_ores", ores_b, 1);

        // boot with an early zero-mask request held pending
        rst_a = 1'b0;
        cyc = 0;
        while (cyc <= 22) begin
            chk("boot_ores", ores_a, boot_rst(cyc));
            chk("boot_ocen", ocen_a, 5'b11111);
            chk("boot_bdone", bdone_a, (cyc >= 20) ? 1 : 0);
            chk("boot_ready", ready_a, (cyc >= 20) ? 1 : 0);
            chk("zero_done", done_a, (cyc == 21) ? 1 : 0);
            if (cyc == 5) valid_a = 1'b1;
            if (cyc == 21) valid_a = 1'b0;
            tick();
        end

        // single request, mask 00101 at 30
        while (cyc < 30) tick();
        valid_a = 1'b1;
        mask_a  = 5'b00101;
        tick();
        valid_a = 1'b0;
        while (cyc <= 43) begin
            chk("one_ores", ores_a, (cyc <= 40) ? 5'b00101 : 5'b00000);
            chk("one_ocen", ocen_a,
                (cyc >= 39 && cyc <= 41) ? 5'b11010 : 5'b11111);
            chk("one_done", done_a, (cyc == 42) ? 1 : 0);
            chk("one_ready", ready_a, (cyc >= 42) ? 1 : 0);
            tick();
        end

        // back-to-back: 00001 at 50, 00011 held until accepted at 62
        while (cyc < 50) tick();
        valid_a = 1'b1;
        mask_a  = 5'b00001;
        tick();
        mask_a  = 5'b00011;
        while (cyc <= 75) begin
            chk("b2b_ores", ores_a,
                (cyc <= 60) ? 5'b00001 :
                (cyc >= 63 && cyc <= 72) ? 5'b00011 : 5'b00000);
            chk("b2b_ocen", ocen_a,
                (cyc >= 59 && cyc <= 61) ? 5'b11110 :
                (cyc >= 71 && cyc <= 73) ? 5'b11100 : 5'b11111);
            chk("b2b_done", done_a, (cyc == 62 || cyc == 74) ? 1 : 0);
            chk("b2b_ready", ready_a, (cyc == 62 || cyc >= 74) ? 1 : 0);
            if (cyc == 63) valid_a = 1'b0;
            tick();
        end

        // reset while in GATE
        while (cyc < 80) tick();
        valid_a = 1'b1;
        mask_a  = 5'b10000;
        tick();
        valid_a = 1'b0;
        while (cyc < 89) tick();
        chk("gate_ores", ores_a, 5'b10000);
        chk("gate_ocen", ocen_a, 5'b01111);
        rst_a = 1'b1;
        tick();
        chk("mid_ores", ores_a, 5'b11111);
        chk("mid_ocen", ocen_a, 5'b11111);
        chk("mid_ready", ready_a, 0);
        chk("mid_bdone", bdone_a, 0);
        rst_a = 1'b0;
        base = cyc;
        while (cyc <= base + 21) begin
            chk("reboot_ores", ores_a, boot_rst(cyc - base));
            chk("reboot_bdone", bdone_a, (cyc - base >= 20) ? 1 : 0);
            tick();
        end

        // minimal instance
        rst_b = 1'b0;
        base = cyc;
        chk("b_boot0", ores_b, 1);
        tick();
        chk("b_boot1", ores_b, 0);
        chk("b_bdone", bdone_b, 1);
        chk("b_ready", ready_b, 1);
        tick();
        tick();
        t = cyc;
        valid_b = 1'b1;
        mask_b  = 1'b1;
        tick();
        valid_b = 1'b0;
        while (cyc <= t + 6) begin
            chk("b_ores", ores_b, (cyc - t <= 3) ? 1 : 0);
            chk("b_ocen", ocen_b,
                (cyc - t >= 2 && cyc - t <= 4) ? 0 : 1);
            chk("b_done", done_b, (cyc - t == 5) ? 1 : 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_domain_reset_sequencer.md
# clock_domain_reset_sequencer

Sequences the resets of the domains fed by one clock/reset broadcast, and gates their clocks. After global reset, domains leave reset one at a time in index order, a fixed gap apart. At run time the block accepts requests to re-reset a subset of domains, and releases each such reset while that domain's clock is stopped. It sits between the broadcast's input clock/reset and the per-domain clock/reset consumers.

## Interface
- NUM_OUT, default 5: number of downstream domains, 1..16.
- GAP, default 4: cycles between successive boot-time reset releases, 1..255.
- PULSE, default 8: cycles a requested domain reset is held with its clock running, 1..255.

- clock  in  1  sole clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high reset.
- out_reset  out  NUM_OUT  per-domain reset, 1 = asserted; registered.
- out_clock_en  out  NUM_OUT  per-domain clock-gate enable, 1 = clock runs; registered.
- boot_done  out  1  high once every domain has been released after reset; sticky until reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in state IDLE.
- req_mask  in  NUM_OUT  domains to re-reset; sampled on handshake.
- done  out  1  one-cycle pulse when a request completes.

## Operation
- Reset values:
  - out_reset = all 1.
  - out_clock_en = all 1 (clocks run so the synchronous resets downstream take effect).
  - boot_done = 0, req_ready = 0, done = 0.
  - state = BOOT; counter = 0; idx = 0; latched mask = 0.
- BOOT:
  - The counter increments each cycle.
  - When counter == GAP-1: clear out_reset[idx], increment idx, zero the counter.
  - After clearing index NUM_OUT-1: go to IDLE and set boot_done.
- IDLE:
  - req_ready = 1.
  - Handshake is req_valid && req_ready.
  - Handshake with req_mask == 0: no state change; done pulses the next cycle.
  - Handshake with a nonzero mask: latch the mask and go to ASSERT.
- ASSERT, PULSE cycles: out_reset[m] = 1 and out_clock_en[m] = 1 for every latched bit m.
- GATE, 2 cycles: out_reset[m] = 1 and out_clock_en[m] = 0.
- RELEASE, 1 cycle: out_reset[m] = 0 and out_clock_en[m] = 0.
- Return to IDLE: out_clock_en[m] = 1, and done pulses for 1 cycle.
- Unmasked domains never change after boot.
- req_valid outside IDLE is ignored; the requester must hold it until ready.
- The counter is $clog2(max(GAP,PULSE))+1 bits wide and never wraps. It is zeroed on every state entry.
- reset mid-operation: every register returns to its reset value on the next edge, regardless of state.

## Timing
- Let cycle 0 be the first cycle in which reset is low.
- out_reset[i] falls at cycle (i+1)*GAP.
- boot_done and req_ready rise at cycle NUM_OUT*GAP.
- For a handshake at cycle t with a nonzero mask:
  - reset high (clock on) in cycles t+1..t+PULSE.
  - clock_en low in cycles t+PULSE+1..t+PULSE+3.
  - reset low from t+PULSE+3.
  - clock_en high, done = 1 and req_ready = 1 in cycle t+PULSE+4.
- Back-to-back requests: the next handshake may occur at t+PULSE+4. A domain in both masks sees reset re-asserted at t+PULSE+5.
- A zero-mask handshake at t gives done = 1 in t+1, with req_ready staying high.
- Every output is a flop output; there is no combinational input-to-output path except none (req_ready is state-decoded).

## Test plan
- Boot, defaults: deassert reset at cycle 0 -> out_reset steps 11111 → 11110 at 4 → 11100 at 8 → 11000 at 12 → 10000 at 16 → 00000 at 20; boot_done and req_ready go high at 20.
- Single request: mask 00101 accepted at t=30 -> out_reset 00101 during 31..38; out_clock_en 11010 during 39..41; out_reset 00000 from 41; done and enables all 1 at 42.
- Back-to-back: mask 00001 at t, then mask 00011 at t+12 -> bit 0 reset re-asserted at t+13, bit 1 at t+13; done at t+12 and t+24.
- Zero mask and early request: req_valid during boot stays pending until cycle 20; a zero mask accepted at t -> done at t+1, outputs unchanged.
- Reset mid-request: assert reset in the GATE state -> next cycle out_reset all 1, out_clock_en all 1, req_ready 0; boot sequence restarts.
- GAP=1, PULSE=1, NUM_OUT=1: out_reset falls at cycle 1; a request at t gives reset at t+1, gated t+2..t+4, done at t+5.
